// File: rtl/serial_sub_pkg.sv
// Shared types and helpers for the chunk-serial subtractor.
// Optional back-to-back mode: SERIAL_SUB_B2B_EN.
package serial_sub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  // Counter width that stays >= 1 even for a single chunk.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/serial_subtractor_sub_chunk.sv
// W-bit ripple chain computing a + ~b + cin.
// Used once by serial_subtractor, one chunk per cycle.
module sub_chunk #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] s,
  output logic         cout
);

  logic [W:0]   c;
  logic [W-1:0] nb;

  assign nb   = ~b;
  assign c[0] = cin;

  for (genvar i = 0; i < W; i++) begin : g_fa
    assign s[i]   = a[i] ^ nb[i] ^ c[i];
    assign c[i+1] = (a[i] & nb[i]) | (c[i] & (a[i] ^ nb[i]));
  end

  assign cout = c[W];

endmodule

// File: rtl/serial_subtractor.sv
// Chunk-serial d = a - b - bin, W bits per cycle, LSB first.
// Define SERIAL_SUB_B2B_EN to accept new operands while retiring a result.
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int N = 32,
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         bin,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] d,
  output logic         bout,
  output logic         zero,
  output logic         ovf
);

  localparam int NCH = N / W;
  localparam int CW  = cnt_w(NCH);

  if (N % W != 0) begin : g_bad_w
    $error("serial_subtractor: N must be a multiple of W");
  end

  state_t         state;
  logic [N-1:0]   a_r;
  logic [N-1:0]   b_r;
  logic           carry;
  logic [CW-1:0]  cnt;
  logic           as_r;
  logic           bs_r;
  logic [W-1:0]   s;
  logic           cout;
  logic [N-1:0]   d_nxt;
  logic           accept;
  logic           last;

  sub_chunk #(.W(W)) u_chunk (
    .a    (a_r[W-1:0]),
    .b    (b_r[W-1:0]),
    .cin  (carry),
    .s    (s),
    .cout (cout)
  );

  // Result fills from the top so chunk 0 lands at the LSB.
  if (NCH == 1) begin : g_one
    assign d_nxt = s;
  end else begin : g_many
    assign d_nxt = {s, d[N-1:W]};
  end

`ifdef SERIAL_SUB_B2B_EN
  assign in_ready = rst_n &
    ((state == IDLE) |
     ((state == DONE) & out_ready));
`else
  assign in_ready = rst_n & (state == IDLE);
`endif

  assign out_valid = (state == DONE);
  assign accept    = in_valid & in_ready;
  assign last      = (cnt == CW'(NCH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      a_r   <= '0;
      b_r   <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      as_r  <= 1'b0;
      bs_r  <= 1'b0;
      d     <= '0;
      bout  <= 1'b0;
      zero  <= 1'b0;
      ovf   <= 1'b0;
    end else if (accept) begin
      a_r   <= a;
      b_r   <= b;
      carry <= ~bin;
      cnt   <= '0;
      as_r  <= a[N-1];
      bs_r  <= b[N-1];
      state <= BUSY;
    end else begin
      unique case (state)
        IDLE: ;
        BUSY: begin
          a_r   <= a_r >> W;
          b_r   <= b_r >> W;
          carry <= cout;
          cnt   <= cnt + CW'(1);
          d     <= d_nxt;
          if (last) begin
            state <= DONE;
            bout  <= ~cout;
            zero  <= (d_nxt == '0);
            ovf   <= (as_r != bs_r) &&
                     (d_nxt[N-1] != as_r);
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (N=32, W=8).
// Directed table, corner sequences and random ops vs. an arithmetic model.
module tb_serial_subtractor;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        bin = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] d;
  logic        bout;
  logic        zero;
  logic        ovf;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  serial_subtractor #(.N(32), .W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .bin       (bin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .d         (d),
    .bout      (bout),
    .zero      (zero),
    .ovf       (ovf)
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        bin;
    logic [31:0] d;
    logic        bout;
    logic        zero;
    logic        ovf;
  } vec_t;

  task automatic check(input string name,
                       input logic [63:0] act,
                       input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               name, act, exp);
    end
  endtask

  // Plain arithmetic: wrap-around difference, borrow as unsigned compare.
  task automatic model(input logic [31:0] ma,
                       input logic [31:0] mb,
                       input logic mbin,
                       output vec_t v);
    logic [33:0] rhs;
    v.a   = ma;
    v.b   = mb;
    v.bin = mbin;
    v.d   = ma - mb - {31'd0, mbin};
    rhs   = {2'b0, mb} + {33'd0, mbin};
    v.bout = ({2'b0, ma} < rhs);
    v.zero = (v.d == 32'd0);
    v.ovf  = (ma[31] != mb[31]) && (v.d[31] != ma[31]);
  endtask

  task automatic start(input logic [31:0] sa,
                       input logic [31:0] sb,
                       input logic sbin);
    int g;
    @(negedge clk);
    a = sa;
    b = sb;
    bin = sbin;
    in_valid = 1'b1;
    g = 0;
    while (!in_ready && g < 20) begin
      @(negedge clk);
      g++;
    end
    check("accept_ready", in_ready, 1);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic check_res(input string tag, input vec_t e);
    check({tag, "_valid"}, out_valid, 1);
    check({tag, "_d"}, d, e.d);
    check({tag, "_bout"}, bout, e.bout);
    check({tag, "_zero"}, zero, e.zero);
    check({tag, "_ovf"}, ovf, e.ovf);
  endtask

  task automatic retire();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    check("retire_valid_low", out_valid, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t tv[7];
    vec_t e;
    int   lat;
    logic [31:0] d_hold;

    tv[0] = '{32'd10, 32'd3, 1'b0, 32'd7, 1'b0, 1'b0, 1'b0};
    tv[1] = '{32'd3, 32'd10, 1'b0, 32'hFFFF_FFF9, 1'b1, 1'b0, 1'b0};
    tv[2] = '{32'h8000_0000, 32'd1, 1'b0,
              32'h7FFF_FFFF, 1'b0, 1'b0, 1'b1};
    tv[3] = '{32'd5, 32'd4, 1'b1, 32'd0, 1'b0, 1'b1, 1'b0};
    tv[4] = '{32'd7, 32'd7, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0};
    tv[5] = '{32'h1234_5678, 32'd0, 1'b0,
              32'h1234_5678, 1'b0, 1'b0, 1'b0};
    tv[6] = '{32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0,
              32'h8000_0000, 1'b1, 1'b0, 1'b1};

    // Reset state
    #1 rst_n = 1'b0;
    #11;
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_d", d, 0);
    check("rst_bout", bout, 0);
    check("rst_zero", zero, 0);
    check("rst_ovf", ovf, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1 check("idle_in_ready", in_ready, 1);

    // Directed table
    for (int i = 0; i < 7; i++) begin
      start(tv[i].a, tv[i].b, tv[i].bin);
      wait_done(lat);
      check($sformatf("tv%0d_lat", i), lat, 4);
      check_res($sformatf("tv%0d", i), tv[i]);
      retire();
    end

    // Backpressure: result held, new operands ignored
    model(32'd100, 32'd1, 1'b0, e);
    start(32'd100, 32'd1, 1'b0);
    wait_done(lat);
    @(negedge clk);
    a = 32'd555;
    b = 32'd5;
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check_res("bp", e);
      check("bp_in_ready", in_ready, 0);
    end
    @(negedge clk);
    in_valid = 1'b0;
    retire();
    repeat (6) @(posedge clk);
    #1 check("bp_no_ghost_op", out_valid, 0);

    // Handshake on both sides in the same DONE cycle
    model(32'd1000, 32'd1, 1'b0, e);
    start(32'd50, 32'd20, 1'b0);
    wait_done(lat);
    @(negedge clk);
    a = 32'd1000;
    b = 32'd1;
    bin = 1'b0;
    in_valid = 1'b1;
    out_ready = 1'b1;
    #1;
`ifdef SERIAL_SUB_B2B_EN
    check("b2b_ready_done", in_ready, 1);
`else
    check("b2b_ready_done", in_ready, 0);
`endif
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    check("b2b_valid_low", out_valid, 0);
`ifdef SERIAL_SUB_B2B_EN
    check("b2b_busy", in_ready, 0);
    wait_done(lat);
    check("b2b_lat", lat, 4);
    check_res("b2b", e);
    retire();
`else
    check("b2b_idle", in_ready, 1);
`endif

    // Reset during chunk 2
    start(32'hDEAD_BEEF, 32'h1111_1111, 1'b0);
    @(posedge clk);
    #1;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_valid", out_valid, 0);
    check("midrst_d", d, 0);
    check("midrst_in_ready", in_ready, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_ready_after", in_ready, 1);
    check("midrst_no_out", out_valid, 0);
    start(tv[2].a, tv[2].b, tv[2].bin);
    wait_done(lat);
    check("midrst_lat", lat, 4);
    check_res("midrst_fresh", tv[2]);
    retire();

    // Random operations with random backpressure
    for (int i = 0; i < 40; i++) begin
      logic [31:0] ra;
      logic [31:0] rb;
      logic        rbin;
      int          hold;
      ra   = $urandom;
      rb   = ($urandom_range(0, 7) == 0) ? ra : $urandom;
      rbin = 1'($urandom_range(0, 1));
      hold = $urandom_range(0, 3);
      model(ra, rb, rbin, e);
      start(ra, rb, rbin);
      wait_done(lat);
      check($sformatf("rnd%0d_lat", i), lat, 4);
      d_hold = d;
      for (int k = 0; k < hold; k++) begin
        @(posedge clk);
        #1;
      end
      check($sformatf("rnd%0d_stable", i), d, d_hold);
      check_res($sformatf("rnd%0d", i), e);
      retire();
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
